i2c_target_responder: RTL and testbench

I2C target (slave) endpoint that answers the team's I2C master transaction formats: 7-bit device address, 16-bit big-endian register pointer, multi-byte write, and read via repeated START with auto-increment. It sits on the board-side bus as an on-chip register/EEPROM model for loopback and self-test of the I2C master path. It exposes a local port for preloading its memory and reports every bus write to the fabric.

---
 rtl/i2c_target_responder_pkg.sv | 37 +++
 rtl/i2c_bus_monitor.sv | 54 +++++
 rtl/i2c_target_responder.sv | 209 ++++++++++++++++++++
 tb/tb_i2c_target_responder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_responder_pkg.sv
// rtl/i2c_target_responder_pkg.sv - shared definitions for the I2C target responder
//
// Purpose: state encodings, default device address, ACK/NACK bus levels,
// command codes shared with the I2C command path, and an address-match helper.
// Ports: none (package).

package i2c_target_responder_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_DEV_ADDR = 4'd1,
    ST_DEV_ACK  = 4'd2,
    ST_PTR_HI   = 4'd3,
    ST_PTR_LO   = 4'd4,
    ST_WR_DATA  = 4'd5,
    ST_RD_DATA  = 4'd6,
    ST_RD_ACK   = 4'd7,
    ST_IGNORE   = 4'd8
  } state_t;

  localparam logic [6:0] DEFAULT_DEVICE_ADDR = 7'h50;

  // Bus level during the acknowledge slot.
  localparam logic SDA_ACK  = 1'b0;
  localparam logic SDA_NACK = 1'b1;

  // Command codes already in use by the I2C command path.
  localparam logic [7:0] I2C_CMD_04 = 8'h04;
  localparam logic [7:0] I2C_CMD_05 = 8'h05;
  localparam logic [7:0] I2C_CMD_06 = 8'h06;

  // Address byte is {addr[6:0], rw}; only the upper seven bits identify the target.
  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev);
    return addr_byte[7:1] == dev;
  endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// rtl/i2c_bus_monitor.sv - SCL/SDA synchronizer with edge and START/STOP detection
//
// Purpose: brings the raw bus pins into the clk domain (2 FF) plus one history
// stage, and derives single-cycle SCL rise/fall, START and STOP events.
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   scl_i, sda_i      raw pin levels
//   sda               synchronized SDA level (valid with the events)
//   scl_rise/scl_fall one-cycle SCL edge events
//   start_det         SDA 1->0 while SCL high
//   stop_det          SDA 0->1 while SCL high

module i2c_bus_monitor (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  // Reset to the idle-bus level so leaving reset never fabricates an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign sda       = sda_s2;
  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  // SCL must be high in both samples so an SDA change next to an SCL edge is not misread.
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

endmodule

// File: rtl/i2c_target_responder.sv
// rtl/i2c_target_responder.sv - I2C target with 16-bit pointer, register memory and write reporting
//
// Purpose: answers DEVICE_ADDR with 16-bit big-endian pointer writes, multi-byte
// writes and auto-incrementing reads (repeated START). Memory is preloadable
// from the local host port; every bus write is reported on wr_*.
// Ports:
//   clk, rst_n                  system clock (>= 16x SCL), asynchronous active-low reset
//   scl_i, sda_i                raw bus pins
//   sda_oe                      1 = pull SDA low
//   host_we/host_addr/host_wdata local memory preload port
//   wr_valid/wr_addr/wr_data    one-cycle report of each byte written from the bus
//   busy                        addressed transaction in progress (until STOP)

module i2c_target_responder
  import i2c_target_responder_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDR = DEFAULT_DEVICE_ADDR,
  parameter int         MEM_DEPTH   = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         scl_i,
  input  logic                         sda_i,
  output logic                         sda_oe,
  input  logic                         host_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] host_addr,
  input  logic [7:0]                   host_wdata,
  output logic                         wr_valid,
  output logic [15:0]                  wr_addr,
  output logic [7:0]                   wr_data,
  output logic                         busy
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic       sda, scl_rise, scl_fall, start_det, stop_det;
  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
  logic [7:0] tx;
  logic [7:0] ptr_hi;
  logic [15:0] ptr;
  logic       rw;
  // In PTR_HI/PTR_LO/WR_DATA: target is driving the ACK slot.
  // In RD_ACK: the master has ACKed and the next byte is loaded.
  logic       ack_slot;
  logic [7:0] rx_byte;
  logic [7:0] mem_rdata;
  logic       bus_we;

  logic [7:0] mem [MEM_DEPTH];

  i2c_bus_monitor u_mon (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign rx_byte   = {shift[6:0], sda};
  assign mem_rdata = mem[ptr[AW-1:0]];
  // Eighth data bit of a write byte, unless a START/STOP overrides this cycle.
  assign bus_we    = (state == ST_WR_DATA) && !ack_slot && scl_rise && (bit_cnt == 4'd7) &&
                     !start_det && !stop_det;

  // Single write port: a bus write takes the port, a coincident host write is dropped.
  always_ff @(posedge clk) begin
    if (bus_we) begin
      mem[ptr[AW-1:0]] <= rx_byte;
    end else if (host_we) begin
      mem[host_addr] <= host_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= 4'd0;
      shift    <= 8'd0;
      tx       <= 8'd0;
      ptr_hi   <= 8'd0;
      ptr      <= 16'd0;
      rw       <= 1'b0;
      ack_slot <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= 16'd0;
      wr_data  <= 8'd0;
    end else begin
      wr_valid <= 1'b0;
      if (stop_det) begin
        state    <= ST_IDLE;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        ack_slot <= 1'b0;
      end else if (start_det) begin
        state    <= ST_DEV_ADDR;
        bit_cnt  <= 4'd0;
        sda_oe   <= 1'b0;
        ack_slot <= 1'b0;
      end else begin
        case (state)
          ST_DEV_ADDR: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (addr_match(shift, DEVICE_ADDR)) begin
                state  <= ST_DEV_ACK;
                sda_oe <= ~SDA_ACK;
                busy   <= 1'b1;
                rw     <= shift[0];
                tx     <= mem_rdata;
              end else begin
                state <= ST_IGNORE;
              end
            end
          end

          ST_DEV_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 4'd0;
              if (rw) begin
                state  <= ST_RD_DATA;
                sda_oe <= ~tx[7];
              end else begin
                state  <= ST_PTR_HI;
                sda_oe <= 1'b0;
              end
            end
          end

          ST_PTR_HI, ST_PTR_LO, ST_WR_DATA: begin
            if (!ack_slot) begin
              if (scl_rise && bit_cnt != 4'd8) begin
                shift   <= rx_byte;
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt == 4'd7) begin
                  case (state)
                    ST_PTR_HI: ptr_hi <= rx_byte;
                    ST_PTR_LO: ptr    <= {ptr_hi, rx_byte};
                    default: begin
                      wr_valid <= 1'b1;
                      wr_addr  <= ptr;
                      wr_data  <= rx_byte;
                    end
                  endcase
                end
              end else if (scl_fall && bit_cnt == 4'd8) begin
                sda_oe   <= ~SDA_ACK;
                ack_slot <= 1'b1;
              end
            end else if (scl_fall) begin
              sda_oe   <= 1'b0;
              ack_slot <= 1'b0;
              bit_cnt  <= 4'd0;
              case (state)
                ST_PTR_HI: state <= ST_PTR_LO;
                ST_PTR_LO: state <= ST_WR_DATA;
                default:   ptr   <= ptr + 16'd1;
              endcase
            end
          end

          ST_RD_DATA: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt != 4'd0) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                ptr     <= ptr + 16'd1;
                bit_cnt <= 4'd0;
                state   <= ST_RD_ACK;
              end else begin
                sda_oe <= ~tx[6];
                tx     <= {tx[6:0], 1'b0};
              end
            end
          end

          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda == SDA_ACK) begin
                tx       <= mem_rdata;
                ack_slot <= 1'b1;
              end else begin
                state <= ST_IGNORE;
              end
            end else if (scl_fall && ack_slot) begin
              ack_slot <= 1'b0;
              bit_cnt  <= 4'd0;
              sda_oe   <= ~tx[7];
              state    <= ST_RD_DATA;
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// tb/tb_i2c_target_responder.sv - directed bench for the I2C target responder

module tb_i2c_target_responder;
  import i2c_target_responder_pkg::*;

  localparam int Q = 5;  // quarter SCL period in clk cycles

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic        sda_oe;
  logic        host_we = 1'b0;
  logic [7:0]  host_addr = 8'd0;
  logic [7:0]  host_wdata = 8'd0;
  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;

  int tests = 0;
  int fails = 0;

  int          cap_n = 0;
  logic [15:0] cap_addr [8];
  logic [7:0]  cap_data [8];
  logic        oe_seen = 1'b0;
  logic        busy_seen = 1'b0;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_responder #(.DEVICE_ADDR(7'h50), .MEM_DEPTH(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (scl),
    .sda_i      (sda_line),
    .sda_oe     (sda_oe),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  always @(negedge clk) begin
    if (wr_valid) begin
      if (cap_n < 8) begin
        cap_addr[cap_n] = wr_addr;
        cap_data[cap_n] = wr_data;
      end
      cap_n = cap_n + 1;
    end
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl = 1'b0;   wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    sda_m = 1'b1; wait_clk(2 * Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;  wait_clk(Q);
    scl = 1'b1; wait_clk(2 * Q);
    scl = 1'b0; wait_clk(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    b = sda_line; wait_clk(Q);
    scl = 1'b0;   wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    acked = (b == 1'b0);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    host_addr = a; host_wdata = d; host_we = 1'b1;
    wait_clk(1);
    host_we = 1'b0;
  endtask

  // START, write address, pointer hi/lo; all_ack = every byte ACKed
  task automatic set_ptr(input logic [15:0] p, output logic all_ack);
    logic a0, a1, a2;
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(p[15:8], a1);
    send_byte(p[7:0], a2);
    all_ack = a0 & a1 & a2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clk(4);
    tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (wr_valid !== 1'b0) begin fails++; $display("FAIL reset_wr_valid: got %b expected 0", wr_valid); end
    tests++; if (wr_addr !== 16'h0000) begin fails++; $display("FAIL reset_wr_addr: got %h expected 0000", wr_addr); end
    tests++; if (wr_data !== 8'h00) begin fails++; $display("FAIL reset_wr_data: got %h expected 00", wr_data); end
    rst_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_write();
    logic ok, a;
    logic [7:0] d;
    cap_n = 0;
    set_ptr(16'h0010, ok);
    send_byte(8'hA5, a);
    tests++; if ((ok & a) !== 1'b1) begin fails++; $display("FAIL write_acks: got %b expected 1", ok & a); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL write_busy: got %b expected 1", busy); end
    i2c_stop();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL write_busy_after_stop: got %b expected 0", busy); end
    tests++; if (cap_n !== 1) begin fails++; $display("FAIL write_wr_valid_count: got %0d expected 1", cap_n); end
    tests++; if (cap_addr[0] !== 16'h0010) begin fails++; $display("FAIL write_wr_addr: got %h expected 0010", cap_addr[0]); end
    tests++; if (cap_data[0] !== 8'hA5) begin fails++; $display("FAIL write_wr_data: got %h expected a5", cap_data[0]); end
    set_ptr(16'h0010, ok);
    i2c_start();
    send_byte(8'hA1, a);
    recv_byte(1'b1, d);
    i2c_stop();
    tests++; if (d !== 8'hA5) begin fails++; $display("FAIL write_readback: got %h expected a5", d); end
  endtask

  task automatic test_read();
    logic ok, a;
    logic [7:0] d;
    logic [7:0] exp [3];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    host_write(8'h20, 8'h11);
    host_write(8'h21, 8'h22);
    host_write(8'h22, 8'h33);
    host_write(8'h23, 8'h44);
    set_ptr(16'h0020, ok);
    i2c_start();
    send_byte(8'hA1, a);
    tests++; if ((ok & a) !== 1'b1) begin fails++; $display("FAIL read_acks: got %b expected 1", ok & a); end
    for (int i = 0; i < 3; i++) begin
      recv_byte(i == 2, d);
      tests++; if (d !== exp[i]) begin fails++; $display("FAIL read_byte%0d: got %h expected %h", i, d, exp[i]); end
    end
    i2c_stop();
    // pointer should now be 0x0023: a bare read returns mem[0x23]
    i2c_start();
    send_byte(8'hA1, a);
    recv_byte(1'b1, d);
    i2c_stop();
    tests++; if (d !== 8'h44) begin fails++; $display("FAIL read_final_ptr: got %h expected 44", d); end
  endtask

  task automatic test_wrong_addr();
    logic a, a2;
    oe_seen = 1'b0;
    busy_seen = 1'b0;
    i2c_start();
    send_byte(8'hA2, a);
    send_byte(8'h00, a2);
    i2c_stop();
    tests++; if (a !== 1'b0) begin fails++; $display("FAIL wrong_addr_ack: got %b expected 0", a); end
    tests++; if (oe_seen !== 1'b0) begin fails++; $display("FAIL wrong_addr_sda_oe: got %b expected 0", oe_seen); end
    tests++; if (busy_seen !== 1'b0) begin fails++; $display("FAIL wrong_addr_busy: got %b expected 0", busy_seen); end
  endtask

  task automatic test_wrap();
    logic ok, a1, a2;
    logic [7:0] d0, d1;
    cap_n = 0;
    set_ptr(16'h00FF, ok);
    send_byte(8'h01, a1);
    send_byte(8'h02, a2);
    i2c_stop();
    tests++; if ((ok & a1 & a2) !== 1'b1) begin fails++; $display("FAIL wrap_acks: got %b expected 1", ok & a1 & a2); end
    tests++; if (cap_n !== 2) begin fails++; $display("FAIL wrap_wr_count: got %0d expected 2", cap_n); end
    tests++; if (cap_addr[0] !== 16'h00FF) begin fails++; $display("FAIL wrap_wr_addr0: got %h expected 00ff", cap_addr[0]); end
    tests++; if (cap_addr[1] !== 16'h0100) begin fails++; $display("FAIL wrap_wr_addr1: got %h expected 0100", cap_addr[1]); end
    tests++; if (cap_data[1] !== 8'h02) begin fails++; $display("FAIL wrap_wr_data1: got %h expected 02", cap_data[1]); end
    set_ptr(16'h00FF, ok);
    i2c_start();
    send_byte(8'hA1, a1);
    recv_byte(1'b0, d0);
    recv_byte(1'b1, d1);
    i2c_stop();
    tests++; if (d0 !== 8'h01) begin fails++; $display("FAIL wrap_mem_ff: got %h expected 01", d0); end
    tests++; if (d1 !== 8'h02) begin fails++; $display("FAIL wrap_mem_00: got %h expected 02", d1); end
  endtask

  task automatic test_stop_mid_read();
    logic ok, a, b;
    host_write(8'h30, 8'hFF);
    set_ptr(16'h0030, ok);
    i2c_start();
    send_byte(8'hA1, a);
    for (int i = 0; i < 3; i++) recv_bit(b);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL stop_mid_busy_before: got %b expected 1", busy); end
    sda_m = 1'b0; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    sda_m = 1'b1; wait_clk(3);
    tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL stop_mid_sda_oe: got %b expected 0", sda_oe); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL stop_mid_busy: got %b expected 0", busy); end
    tests++; if (dut.state !== ST_IDLE) begin fails++; $display("FAIL stop_mid_state: got %0d expected %0d", dut.state, ST_IDLE); end
    wait_clk(2 * Q);
  endtask

  task automatic test_reset_mid_ack();
    logic a;
    logic [7:0] d;
    logic [7:0] addr_byte;
    addr_byte = 8'hA1;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(addr_byte[i]);
    tests++; if (sda_oe !== 1'b1) begin fails++; $display("FAIL rst_ack_driven: got %b expected 1", sda_oe); end
    rst_n = 1'b0;
    #1;
    tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL rst_mid_sda_oe: got %b expected 0", sda_oe); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    tests++; if (wr_addr !== 16'h0000) begin fails++; $display("FAIL rst_mid_wr_addr: got %h expected 0000", wr_addr); end
    tests++; if (wr_data !== 8'h00) begin fails++; $display("FAIL rst_mid_wr_data: got %h expected 00", wr_data); end
    tests++; if (wr_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_wr_valid: got %b expected 0", wr_valid); end
    wait_clk(2);
    scl = 1'b1;
    sda_m = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
    // pointer reset to 0: a bare read returns mem[0x00] written by the wrap test
    i2c_start();
    send_byte(8'hA1, a);
    recv_byte(1'b1, d);
    i2c_stop();
    tests++; if (d !== 8'h02) begin fails++; $display("FAIL rst_ptr_zero: got %h expected 02", d); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrong_addr();
    test_wrap();
    test_stop_mid_read();
    test_reset_mid_ack();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
